// File: rtl/alu_acc_stage_pkg.sv
// alu_acc_stage_pkg: shared definitions for the accumulator execute stage.
//   - ALU opcode encodings (OP_ADD .. OP_EQ)
//   - FSM state encoding (IDLE/EXEC/RESP)
//   - bit positions inside the 5-bit flag vector {less, equal, carry, overflow, zero}
package alu_acc_stage_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FLG_LESS = 4;
  localparam int FLG_EQ   = 3;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF  = 1;
  localparam int FLG_ZERO = 0;

  localparam logic [3:0] ACC_RST = 4'b0000;

endpackage

// File: rtl/alu_signed_4bits.sv
// alu_signed_4bits: purely combinational 4-bit signed ALU.
// Ports:
//   a, b    in  4  operands (two's complement)
//   opt     in  3  opcode (see alu_acc_stage_pkg)
//   result  out 4  operation result
//   flags   out 5  {less, equal, carry, overflow, zero}
// Sub and both compares evaluate a + ~b + 1; carry is the raw adder
// carry-out (1 means "no borrow"). less/equal always describe a vs b as
// signed values; carry/overflow are 0 for the logic ops.
import alu_acc_stage_pkg::*;

module alu_signed_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] opt,
  output logic [3:0] result,
  output logic [4:0] flags
);

  logic [4:0] add_sum;
  logic [4:0] sub_sum;
  logic       add_ovf;
  logic       sub_ovf;
  logic       carry;
  logic       ovf;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
  assign add_ovf = (a[3] == b[3]) && (add_sum[3] != a[3]);
  assign sub_ovf = (a[3] != b[3]) && (sub_sum[3] != a[3]);

  always_comb begin
    result = 4'b0000;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (opt)
      OP_ADD: begin
        result = add_sum[3:0];
        carry  = add_sum[4];
        ovf    = add_ovf;
      end
      OP_SUB, OP_LT, OP_EQ: begin
        result = sub_sum[3:0];
        carry  = sub_sum[4];
        ovf    = sub_ovf;
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = a ^ b;
    endcase
  end

  always_comb begin
    flags            = 5'b00000;
    // Signed a < b: sign of the difference corrected by overflow.
    flags[FLG_LESS]  = sub_sum[3] ^ sub_ovf;
    flags[FLG_EQ]    = (a == b);
    flags[FLG_CARRY] = carry;
    flags[FLG_OVF]   = ovf;
    flags[FLG_ZERO]  = (result == 4'b0000);
  end

endmodule

// File: rtl/alu_acc_stage.sv
// alu_acc_stage: valid/ready execute stage around alu_signed_4bits with a
// 4-bit accumulator as operand A and the command immediate as operand B.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          command handshake
//   in_load, in_op, in_imm     command: load imm, or ALU op with imm as B
//   out_valid/out_ready        result handshake
//   out_result, out_flags      registered result and {less,equal,carry,ovf,zero}
//   acc                        architectural accumulator
//   sticky_ovf                 accumulated add/sub overflow
// Build option: define ALU_ACC_STICKY_EN to implement sticky_ovf; otherwise
// it is tied to 0.
// FSM: IDLE (accept) -> EXEC (ALU evaluates, results registered) -> RESP
// (hold until out_ready) -> IDLE. Peak rate is one command per 3 cycles.
import alu_acc_stage_pkg::*;

module alu_acc_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_load,
  input  logic [2:0] in_op,
  input  logic [3:0] in_imm,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic [4:0] out_flags,
  output logic [3:0] acc,
  output logic       sticky_ovf
);

  state_t     state;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_imm;
  logic [3:0] alu_result;
  logic [4:0] alu_flags;

  alu_signed_4bits u_alu (
    .a      (acc),
    .b      (cmd_imm),
    .opt    (cmd_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= 4'b0000;
      out_flags  <= 5'b00000;
      acc        <= ACC_RST;
      cmd_load   <= 1'b0;
      cmd_op     <= 3'b000;
      cmd_imm    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cmd_load <= in_load;
            cmd_op   <= in_op;
            cmd_imm  <= in_imm;
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cmd_load) begin
            out_result <= cmd_imm;
            out_flags  <= {4'b0000, cmd_imm == 4'b0000};
            acc        <= cmd_imm;
          end else begin
            out_result <= alu_result;
            out_flags  <= alu_flags;
            // Compare ops (LT/EQ) report only; the accumulator is kept.
            if (cmd_op != OP_LT && cmd_op != OP_EQ) acc <= alu_result;
          end
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_ACC_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (state == EXEC) begin
      if (cmd_load)
        sticky_q <= 1'b0;
      else if ((cmd_op == OP_ADD || cmd_op == OP_SUB) && alu_flags[FLG_OVF])
        sticky_q <= 1'b1;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  assign sticky_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_acc_stage.sv
// tb_alu_acc_stage: directed self-checking bench for alu_acc_stage.
// Expected results come from an integer-arithmetic model and are queued when
// a command is driven; the output monitor pops and compares on each result
// handshake. Inputs change 1 time unit after the rising edge, outputs are
// sampled on the falling edge or 1 unit after the rising edge.
module tb_alu_acc_stage;
  import alu_acc_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_load = 1'b0;
  logic [2:0] in_op = 3'b000;
  logic [3:0] in_imm = 4'b0000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic [4:0] out_flags;
  logic [3:0] acc;
  logic       sticky_ovf;

`ifdef ALU_ACC_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] res;
    logic [4:0] flg;
    logic [3:0] acc;
    logic       stk;
  } exp_t;

  exp_t       sbq[$];
  time        acc_t[$];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] m_acc = 4'b0000;
  logic       m_stk = 1'b0;

  alu_acc_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_load    (in_load),
    .in_op      (in_op),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .acc        (acc),
    .sticky_ovf (sticky_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic ld, input logic [2:0] op, input logic [3:0] imm,
                       output exp_t e);
    int ua, ub, sa, sb, u, s;
    logic [3:0] r;
    logic c, v, lt, eq;
    ua = int'(m_acc);
    ub = int'(imm);
    sa = int'($signed(m_acc));
    sb = int'($signed(imm));
    u = 0; s = 0; c = 1'b0; v = 1'b0; r = 4'b0000;
    lt = (sa < sb);
    eq = (ua == ub);
    if (ld) begin
      m_acc = imm;
      m_stk = 1'b0;
      e.res = imm;
      e.flg = {4'b0000, imm == 4'b0000};
    end else begin
      if (op == OP_ADD) begin
        u = ua + ub; s = sa + sb;
      end else if (op == OP_SUB || op == OP_LT || op == OP_EQ) begin
        u = ua + (15 - ub) + 1; s = sa - sb;
      end
      case (op)
        OP_NOT:  r = ~m_acc;
        OP_AND:  r = m_acc & imm;
        OP_OR:   r = m_acc | imm;
        OP_XOR:  r = m_acc ^ imm;
        default: begin
          r = 4'(u);
          c = (u > 15);
          v = (s > 7) || (s < -8);
        end
      endcase
      e.res = r;
      e.flg = {lt, eq, c, v, r == 4'b0000};
      if (STK && v && (op == OP_ADD || op == OP_SUB)) m_stk = 1'b1;
      if (op != OP_LT && op != OP_EQ) m_acc = r;
    end
    e.acc = m_acc;
    e.stk = m_stk;
  endtask

  // Drive one command once the stage is ready; returns 1 unit after accept.
  task automatic send(input logic ld, input logic [2:0] op, input logic [3:0] imm);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_timeout", 16'(in_ready), 16'd1);
    if (in_ready) begin
      in_valid = 1'b1; in_load = ld; in_op = op; in_imm = imm;
      model(ld, op, imm, e);
      sbq.push_back(e);
      @(posedge clk);
      acc_t.push_back($time);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("drain", 16'(sbq.size()), 16'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("spurious_out", 16'(sbq.size() != 0), 16'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("result", 16'(out_result), 16'(e.res));
        check("flags",  16'(out_flags),  16'(e.flg));
        check("acc",    16'(acc),        16'(e.acc));
        check("sticky", 16'(sticky_ovf), 16'(e.stk));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] snap_r;
    logic [4:0] snap_f;
    int n;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready",  16'(in_ready),   16'd1);
    check("rst_out_valid", 16'(out_valid),  16'd0);
    check("rst_result",    16'(out_result), 16'd0);
    check("rst_flags",     16'(out_flags),  16'd0);
    check("rst_acc",       16'(acc),        16'(ACC_RST));
    check("rst_sticky",    16'(sticky_ovf), 16'd0);
    out_ready = 1'b1;

    // 5 + 3 -> signed overflow
    send(1'b1, OP_ADD, 4'd5);
    send(1'b0, OP_ADD, 4'd3);
    drain();
    check("add_res",    16'(out_result), 16'(4'b1000));
    check("add_flags",  16'(out_flags),  16'(5'b00010));
    check("add_acc",    16'(acc),        16'(4'b1000));
    check("add_sticky", 16'(sticky_ovf), 16'(STK));

    // 2 - 2 -> zero, carry (no borrow); the load clears sticky
    send(1'b1, OP_ADD, 4'd2);
    send(1'b0, OP_SUB, 4'd2);
    drain();
    check("sub_flags",  16'(out_flags),  16'(5'b01101));
    check("sub_acc",    16'(acc),        16'd0);
    check("sub_sticky", 16'(sticky_ovf), 16'd0);

    // compares leave acc alone
    send(1'b1, OP_ADD, 4'b1110);
    send(1'b0, OP_LT, 4'd1);
    drain();
    check("lt_flags", 16'(out_flags), 16'(5'b10100));
    check("lt_acc",   16'(acc),       16'(4'b1110));
    send(1'b0, OP_EQ, 4'b1110);
    drain();
    check("eq_flags", 16'(out_flags),  16'(5'b01101));
    check("eq_res",   16'(out_result), 16'd0);
    check("eq_acc",   16'(acc),        16'(4'b1110));

    // back-pressure: 5 stalled cycles with in_valid pulsing
    out_ready = 1'b0;
    send(1'b0, OP_XOR, 4'h5);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("stall_valid_timeout", 16'(out_valid), 16'd1);
    snap_r = out_result;
    snap_f = out_flags;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~i[0]; in_load = 1'b1; in_op = OP_ADD; in_imm = 4'hF;
      check("stall_res",   16'(out_result), 16'(snap_r));
      check("stall_flags", 16'(out_flags),  16'(snap_f));
      check("stall_ready", 16'(in_ready),   16'd0);
      check("stall_valid", 16'(out_valid),  16'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", 16'(out_valid), 16'd0);
    check("stall_release_ready", 16'(in_ready),  16'd1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_no_second_cmd", 16'(out_valid), 16'd0);
    check("stall_acc",           16'(acc),       16'(m_acc));
    check("stall_queue",         16'(sbq.size()), 16'd0);

    // reset while an add is in EXEC
    send(1'b1, OP_ADD, 4'd6);
    send(1'b0, OP_ADD, 4'd3);
    drain();
    check("pre_rst_acc", 16'(acc), 16'(4'b1001));
    in_valid = 1'b1; in_load = 1'b0; in_op = OP_ADD; in_imm = 4'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_acc = ACC_RST;
    m_stk = 1'b0;
    check("mid_rst_acc",    16'(acc),        16'(ACC_RST));
    check("mid_rst_valid",  16'(out_valid),  16'd0);
    check("mid_rst_ready",  16'(in_ready),   16'd1);
    check("mid_rst_sticky", 16'(sticky_ovf), 16'd0);
    check("mid_rst_flags",  16'(out_flags),  16'd0);
    repeat (3) @(posedge clk);
    #1 check("post_rst_idle", 16'(out_valid), 16'd0);

    // back-to-back throughput
    acc_t.delete();
    send(1'b1, OP_ADD, 4'd7);
    send(1'b0, OP_NOT, 4'd0);
    send(1'b0, OP_AND, 4'hC);
    drain();
    check("b2b_count", 16'(acc_t.size()), 16'd3);
    if (acc_t.size() >= 3) begin
      check("b2b_gap0", 16'(acc_t[1] - acc_t[0]), 16'd30);
      check("b2b_gap1", 16'(acc_t[2] - acc_t[1]), 16'd30);
    end
    check("b2b_res", 16'(out_result), 16'(4'b1000));
    check("b2b_acc", 16'(acc),        16'(4'b1000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_acc_stage.md
# alu_acc_stage

Sequential execute stage wrapped around the 4-bit signed combinational ALU (`alu_signed_4bits`). It accepts one command per valid/ready handshake and drives the ALU with a 4-bit accumulator as A and the command immediate as B. It registers the ALU result and flags, and presents them on a valid/ready output port. It sits between the command source (switch/key front end or testbench driver) and the display/flag consumer, and turns the bare ALU into a pipelined, back-pressurable unit with architectural state.

## Interface
- `ACC_RST`, 4'b0000, accumulator value after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  stage can accept a command.
- `in_load`  in  1  1: load `in_imm` into the accumulator; 0: ALU operation.
- `in_op`  in  3  ALU opcode: 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 less-than, 111 equal.
- `in_imm`  in  4  B operand, or load value.
- `out_valid`  out  1  result/flags held valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  4  registered ALU result, or the loaded value.
- `out_flags`  out  5  {less, equal, carry, overflow, zero}, registered.
- `acc`  out  4  current accumulator.
- `sticky_ovf`  out  1  accumulated overflow; see Configuration.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `in_ready`=1. On `in_valid`, capture `in_load`/`in_op`/`in_imm` into command registers and go to EXEC.
- EXEC: ALU inputs are A=`acc`, B=captured imm, opt=captured op.
  - Load command: `out_result`=imm, `acc`=imm. zero=(imm==0); all other flags 0.
  - Ops 000–101: `out_result`=ALU result, `acc`=ALU result, and all five ALU flags are registered.
  - Ops 110/111: result and flags are registered; `acc` is not written (compare only).
  - Go to RESP with `out_valid`=1.
- RESP: outputs are held stable until `out_ready`=1, then go to IDLE. `out_valid` drops on the next edge.
- Arithmetic is 4-bit modulo. Overflow and carry use the ALU's definition: sub/compare add ~B+1, and carry is the raw adder carry-out, not borrow.
- `in_ready`=0 in EXEC and RESP. Commands presented then are ignored and must be held by the source.
- Reset values: state=IDLE, `in_ready`=1 after reset, `out_valid`=0, `out_result`=0, `out_flags`=0, `acc`=`ACC_RST`, `sticky_ovf`=0, command registers 0.
- Reset has priority over every event. Reset in EXEC or RESP discards the in-flight command with no `acc` update.

## Timing
- Command accepted at edge N (IDLE, `in_valid`=1). Result registered and `out_valid`=1 after edge N+1. Earliest next accept is at edge N+3 (RESP→IDLE at N+2, given `out_ready`=1).
- Peak throughput is one command per 3 cycles. Each cycle of `out_ready`=0 in RESP adds one cycle.
- `out_ready` asserted while `out_valid`=0 has no effect.
- The ALU is purely combinational inside EXEC. There is no path from `in_*` to `out_*` inside a single cycle.

## Configuration
- `ALU_ACC_STICKY_EN` defined:
  - `sticky_ovf` sets in EXEC on any op 000/001 with overflow=1.
  - It clears only on a load command, or on reset; on a load command it clears in that EXEC cycle.
  - Compare ops never set it.
- Undefined: `sticky_ovf` is tied to 0 and no register is inferred.

## Structure
- Shared package holds:
  - the opcode localparams (OP_ADD … OP_EQ);
  - the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the flag bit indices (FLG_LESS=4 … FLG_ZERO=0).
- Exactly one sub-module, `alu_signed_4bits`, is instantiated combinationally in the EXEC datapath. The stage itself holds only the FSM, command, accumulator and output registers.

## Test plan
- Reset, then load 4'd5, then add imm 4'd3 → result 4'b1000, overflow=1, carry=0, zero=0, acc=1000. With macro: `sticky_ovf`=1.
- acc=4'd2, sub imm 4'd2 → result 0, zero=1, carry=1, overflow=0, acc=0.
- acc=4'b1110 (-2), op 110 imm 4'd1 → less=1, acc unchanged at 1110. Then op 111 imm 4'b1110 → equal=1, zero=1, acc unchanged.
- `out_ready` held low 5 cycles in RESP, with `in_valid` pulsed during the stall:
  - `out_result`/`out_flags` stable throughout;
  - `in_ready`=0 throughout;
  - no second command captured;
  - `out_valid` falls one edge after `out_ready`.
- `rst_n` low during EXEC of an add: acc returns to `ACC_RST`, `out_valid`=0, state IDLE, `sticky_ovf`=0.
- Back-to-back commands with `out_ready`=1: accepts spaced exactly 3 cycles apart. Load 4'd7, then not → result 4'b1000, acc=1000.
